// File: rtl/ex3_serial_adder.sv
// Digit-serial excess-3 adder: one decimal digit per clock, LSD first.
// A start in IDLE loads both operands; done pulses once the NDIG digits have been summed.
module ex3_serial_adder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] a_ex,
  input  logic [4*NDIG-1:0] b_ex,
  output logic [4*NDIG-1:0] sum_ex,
  output logic              cout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W     = 4 * NDIG;
  localparam int CNT_W = $clog2(NDIG) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [4:0]       dig;

  // Returns {carry, excess-3 digit}. The binary carry of the 4-bit add is exactly
  // the decimal carry, because the two +3 biases add up to a +6 correction.
  function automatic logic [4:0] ex3_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (s[4]) return {1'b1, s[3:0] + 4'd3};
    else      return {1'b0, s[3:0] - 4'd3};
  endfunction

  function automatic logic bad_digit(input logic [3:0] d);
    return (d < 4'd3) || (d > 4'd12);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    done_d  = 1'b0;
    dig     = ex3_add(a_q[3:0], b_q[3:0], carry_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_ex;
          b_d     = b_ex;
          carry_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = (sum_q >> 4) | (W'(dig[3:0]) << (W - 4));
        carry_d = dig[4];
        err_d   = err_q | bad_digit(a_q[3:0]) | bad_digit(b_q[3:0]);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Operand shifters are pure datapath; they are reloaded by every accepted start.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign sum_ex = sum_q;
  assign cout   = carry_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ex3_serial_adder.sv
// Bench for ex3_serial_adder: stimulus pushes decimal-model expectations into a
// scoreboard; a monitor pops and checks one entry per done pulse.
module tb_ex3_serial_adder;
  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_ex = '0;
  logic [W-1:0] b_ex = '0;
  logic [W-1:0] sum_ex;
  logic         cout, busy, done, err;

  ex3_serial_adder #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_ex(a_ex), .b_ex(b_ex),
    .sum_ex(sum_ex), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         bad;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal reference: decode digits, add as integers, re-encode with +3.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int dcyc);
    exp_t e;
    int   av, bv, p, s;
    logic [3:0] da, db;
    av = 0; bv = 0; p = 1;
    e.bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da < 3 || da > 12 || db < 3 || db > 12) e.bad = 1'b1;
      av += (int'(da) - 3) * p;
      bv += (int'(db) - 3) * p;
      p  *= 10;
    end
    s    = av + bv;
    e.co = (s >= p);
    s    = s % p;
    e.sum = '0;
    for (int i = 0; i < NDIG; i++) begin
      e.sum[4*i +: 4] = 4'((s % 10) + 3);
      s = s / 10;
    end
    e.done_cyc = dcyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", e.done_cyc, cyc);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("err", {31'd0, err}, {31'd0, e.bad});
        if (!e.bad) begin
          check("sum_ex", {{(32-W){1'b0}}, sum_ex}, {{(32-W){1'b0}}, e.sum});
          check("cout", {31'd0, cout}, {31'd0, e.co});
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_op(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'(3 + $urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 3) == 0)
      v[4*$urandom_range(0, NDIG-1) +: 4] = ($urandom_range(0, 1) == 0) ? 4'(
        $urandom_range(0, 2)) : 4'(13 + $urandom_range(0, 2));
    return v;
  endfunction

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, sb.size() != 0}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // poke: pulse start again two edges into the run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    @(negedge clk);
    a_ex = a; b_ex = b; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(a, b, cyc + NDIG));
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("err_cleared_on_start", {31'd0, err}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    a_ex = rand_op(1'b1); b_ex = rand_op(1'b1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1; a_ex = rand_op(1'b0); b_ex = rand_op(1'b0);
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_sum", {{(32-W){1'b0}}, sum_ex}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h4567, 16'h89AB, 1'b0);
    run_op(16'hCCCC, 16'h3334, 1'b0);
    run_op(16'h3333, 16'h3333, 1'b0);
    run_op(16'h333F, 16'h3333, 1'b0);
    check("err_held_after_done", {31'd0, err}, 32'd1);
    run_op(16'h4567, 16'h3334, 1'b0);
    run_op(16'h5678, 16'hABCC, 1'b1);

    // Abort mid-operation with an asynchronous reset between edges k+2 and k+3.
    @(negedge clk);
    a_ex = 16'h4567; b_ex = 16'h89AB; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {{(32-W){1'b0}}, sum_ex}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h9999, 16'h4444, 1'b0);

    // Start held high: back-to-back operations every NDIG+1 edges.
    @(negedge clk);
    a_ex = rand_op(1'b0); b_ex = rand_op(1'b0); start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sb.push_back(model(a_ex, b_ex, cyc + NDIG));
      check("b2b_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      a_ex = rand_op(1'b0); b_ex = rand_op(1'b0);
      if (i < 2) repeat (NDIG) @(posedge clk);
      else start = 1'b0;
    end
    drain();

    for (int i = 0; i < 16; i++) run_op(rand_op(1'b1), rand_op(1'b1), ($urandom_range(0, 3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex3_serial_adder.md
EX3_SERIAL_ADDER -- requirements
Module: ex3_serial_adder

Interface
REQ-001 Parameter NDIG, default 4: number of decimal digits per operand; legal range is 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a_ex, input, 4*NDIG bits: operand A as excess-3 digits; digit 0 is in [3:0] (least significant).
REQ-006 The block SHALL have port b_ex, input, 4*NDIG bits: operand B, same packing as a_ex.
REQ-007 The block SHALL have port sum_ex, output, 4*NDIG bits: excess-3 sum, same packing as a_ex.
REQ-008 The block SHALL have port cout, output, 1 bit: decimal carry out of the most significant digit.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum_ex/cout/err valid.
REQ-011 The block SHALL have port err, output, 1 bit: an operand digit code outside 0011..1100 was seen during the last operation.

Function
REQ-012 FSM states SHALL be IDLE and RUN, with a digit counter of width clog2(NDIG)+1 bits.
REQ-013 In IDLE, start=1 at edge k SHALL:
  - load a_ex and b_ex into internal shift registers;
  - clear the carry flip-flop, the counter and err;
  - set busy=1 and enter RUN.
REQ-014 Each RUN edge SHALL process digit 0 of the shift registers:
  - s = a_d + b_d + carry, as a 5-bit sum;
  - if s[4]=1, result digit = s[3:0]+3 (mod 16) and carry=1;
  - else result digit = s[3:0]-3 (mod 16) and carry=0.
REQ-015 Each RUN edge SHALL shift the operand registers right by one digit and shift the result digit into the top digit of the sum register.
REQ-016 After NDIG RUN edges (edge k+NDIG), the block SHALL:
  - return to IDLE and set busy=0;
  - set done=1 for exactly the cycle following edge k+NDIG;
  - drive cout = final carry.
REQ-017 Latency SHALL be fixed: done is sampled high at edge k+NDIG+1 regardless of operand values.
REQ-018 sum_ex, cout and err SHALL hold their values from the end of an operation until the next accepted start.
REQ-019 sum_ex and cout SHALL be don't-care while busy=1.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-021 start held high continuously SHALL begin a new operation at the first edge in IDLE, which is the edge on which done is high, giving back-to-back operations.
REQ-022 err SHALL be set on a RUN edge where either processed digit is <0011 or >1100.
  - err is sticky until the next accepted start.
  - The arithmetic still completes and the result is unspecified.
REQ-023 Operand changes on a_ex and b_ex after the start edge SHALL NOT affect the operation.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, without waiting for a clock edge, with busy=0, done=0, err=0, cout=0, sum_ex=0, carry=0 and counter=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation, produce no done pulse, and discard the partial result.
REQ-026 After rst_n deasserts, the first start SHALL be accepted at the first rising edge on which rst_n=1 and start=1.

Verification
REQ-027 With NDIG=4, a_ex=0x4567 (1234) and b_ex=0x89AB (5678), a start pulse SHALL produce done at edge k+5 with sum_ex=0x9C45 (6912), cout=0, err=0.
REQ-028 a_ex=0xCCCC (9999) and b_ex=0x3334 (0001) SHALL produce sum_ex=0x3333 and cout=1, exercising the carry ripple through all digits.
REQ-029 a_ex=0x3333 and b_ex=0x3333 SHALL produce sum_ex=0x3333, cout=0; a_ex=0x333F SHALL produce err=1 at done, and err SHALL be cleared by the next valid start.
REQ-030 A start pulse during RUN SHALL leave the result and timing of the current operation unchanged, with no second done pulse.
REQ-031 rst_n pulsed low between edges k+2 and k+3 SHALL drive busy=0 immediately, produce no done, and leave sum_ex=0; a following operation SHALL complete correctly.
REQ-032 start held high for three operations SHALL produce done pulses at edges k+5, k+10 and k+15, each with the correct sum for the operands present at its start edge.
